type2_mac_ec: RTL and testbench
===============================

// Module: type2_mac_ec
// PURPOSE
//  Type-2 error-compensation MAC processing element for a weight-stationary systolic DNN
//  accelerator running at low (timing-marginal) voltage. Multiplies weight x activation,
//  accumulates into the vertical partial-sum chain and forwards the activation east.
//  A late re-sample check detects a corrupted accumulation. On an error the local product
//  is not added locally; it is deferred to the next PE, which adds it when its error_in is set.
// PARAMETERS
//  W_W    8   weight width (unsigned)
//  A_W    8   activation width (unsigned)
//  PS_W   24  partial-sum width
//  PR_W   16  product / error-product width; must equal W_W+A_W
// PORTS
//  clk                in   1     single clock, rising edge
//  rst_n              in   1     asynchronous active-low reset
//  weight             in   W_W   stationary weight operand
//  activation         in   A_W   activation from west neighbour
//  partial_sum_in     in   PS_W  partial sum from north neighbour
//  error_product_in   in   PR_W  product deferred by upstream PE
//  error_in           in   1     1 = upstream deferred error_product_in; add it here
//  delay_clk          in   1     sync late-sample strobe, sampled on clk; 1 = check cycle
//  next_activation    out  A_W   registered activation to east neighbour
//  partial_sum_out    out  PS_W  registered partial sum to south neighbour
//  error_product_out  out  PR_W  registered deferred product; 0 when no error
// BEHAVIOUR
//  - Reset (rst_n=0, async): next_activation, partial_sum_out, error_product_out <= 0.
//    Release is synchronous to clk. Reset mid-operation drops any deferred product.
//  - Combinational terms:
//    prod = weight*activation, unsigned, PR_W bits.
//    comp = error_in ? error_product_in : 0.
//    full = partial_sum_in + zext(prod) + zext(comp), mod 2^PS_W (wraps, no saturation).
//    base = partial_sum_in + zext(comp), mod 2^PS_W.
//  - error_product_in is ignored when error_in=0, even if it is non-zero.
//  - Latency: 1 clk for every output. next_activation <= activation on every edge.
//  - Normal cycle (delay_clk=0 at the edge):
//    partial_sum_out <= full; error_product_out <= 0.
//  - Check cycle (delay_clk=1 at the edge): the operands are required to be held from the
//    previous edge; full is re-evaluated and compared with the current partial_sum_out.
//    * match    -> partial_sum_out <= full; error_product_out <= 0.
//    * mismatch -> timing error: partial_sum_out <= base; error_product_out <= prod.
//      The downstream PE drives its error_in from |error_product_out (external wiring).
//  - Deferral is one hop only. Upstream compensation (comp) is still added on an error
//    cycle; only the local product is deferred.
//  - Consecutive check cycles are legal; each one compares against the latest register value.
//  - A zero product on an error cycle gives error_product_out=0. This is harmless: nothing
//    is owed downstream.
// STRUCTURE
//  - Package mac_pkg: W_W/A_W/PS_W/PR_W localparams and typedefs weight_t, act_t, psum_t,
//    prod_t.
//  - Sub-module mac_mul_add (combinational): produces prod, full and base.
//  - The top level holds the three output registers and the check/compare logic.
// TESTING
//  1. rst_n=0 with arbitrary inputs -> all outputs 0 immediately, independent of clk.
//  2. w=0x10, a=0x02, ps_in=0x004000, err_in=0, delay_clk=0 -> ps_out=0x004020,
//     ep_out=0, next_act=0x02.
//  3. w=0x20, a=0x03, ps_in=0x000008, ep_in=0x0012, err_in=0 -> ps_out=0x000068
//     (ep_in ignored).
//  4. w=0x10, a=0x02, ps_in=0x002000, ep_in=0x0012, err_in=1 -> ps_out=0x002032.
//  5. Edge1 ps_in=0x004000, w=0x10, a=0x02 (ps_out=0x004020). Edge2 delay_clk=1,
//     ps_in=0x008000 -> mismatch -> ps_out=0x008000, ep_out=0x0020.
//     Same test with ps_in held at 0x004000 -> ps_out=0x004020, ep_out=0.
//  6. ps_in=0xFFFFF0, w=0xFF, a=0xFF -> ps_out=0x00FDF1 (wrap); ep_out=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and operand types for the type-2 error-compensating MAC PE.
package mac_pkg;
   localparam int W_W  = 8;
   localparam int A_W  = 8;
   localparam int PS_W = 24;
   localparam int PR_W = 16;

   typedef logic [W_W-1:0]  weight_t;
   typedef logic [A_W-1:0]  act_t;
   typedef logic [PS_W-1:0] psum_t;
   typedef logic [PR_W-1:0] prod_t;
endpackage

// File: rtl/mac_mul_add.sv
// Combinational datapath: weight*activation product, accumulation with and without
// the local product (both include upstream compensation). Zero latency, no backpressure.
module mac_mul_add
   import mac_pkg::*;
(
   input  weight_t weight,
   input  act_t    activation,
   input  psum_t   partial_sum_in,
   input  prod_t   error_product_in,
   input  logic    error_in,
   output prod_t   prod,
   output psum_t   full,
   output psum_t   base
);
   prod_t comp;

   assign prod = PR_W'(weight) * PR_W'(activation);
   // Upstream product is only owed when the neighbour flags it; stale values are dropped.
   assign comp = error_in ? error_product_in : '0;
   assign base = partial_sum_in + PS_W'(comp);
   assign full = base + PS_W'(prod);
endmodule

// File: rtl/type2_mac_ec.sv
// Systolic MAC PE with late-sample error detection and one-hop product deferral.
// All outputs registered, 1 clk latency; no backpressure (systolic lockstep).
module type2_mac_ec
   import mac_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  weight_t weight,
   input  act_t    activation,
   input  psum_t   partial_sum_in,
   input  prod_t   error_product_in,
   input  logic    error_in,
   input  logic    delay_clk,
   output act_t    next_activation,
   output psum_t   partial_sum_out,
   output prod_t   error_product_out
);
   prod_t  prod;
   psum_t  full;
   psum_t  base;
   act_t   act_q;
   psum_t  ps_q;
   prod_t  ep_q;
   logic   timing_err;

   mac_mul_add u_mul_add (
      .weight           (weight),
      .activation       (activation),
      .partial_sum_in   (partial_sum_in),
      .error_product_in (error_product_in),
      .error_in         (error_in),
      .prod             (prod),
      .full             (full),
      .base             (base)
   );

   // Operands are held into a check cycle, so a correct register must equal a fresh full.
   assign timing_err = delay_clk && (full != ps_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q <= '0;
         ps_q  <= '0;
         ep_q  <= '0;
      end else begin
         act_q <= activation;
         if (timing_err) begin
            ps_q <= base;
            ep_q <= prod;
         end else begin
            ps_q <= full;
            ep_q <= '0;
         end
      end
   end

   assign next_activation   = act_q;
   assign partial_sum_out   = ps_q;
   assign error_product_out = ep_q;
endmodule

// File: tb/tb_type2_mac_ec.sv
// Randomized and directed bench for type2_mac_ec against an arithmetic reference model.
module tb_type2_mac_ec;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  weight;
   logic [7:0]  activation;
   logic [23:0] partial_sum_in;
   logic [15:0] error_product_in;
   logic        error_in;
   logic        delay_clk;
   logic [7:0]  next_activation;
   logic [23:0] partial_sum_out;
   logic [15:0] error_product_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: what the outputs should show after the last edge.
   longint m_ps, m_ep, m_act;

   always #5 clk = ~clk;

   type2_mac_ec dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .weight            (weight),
      .activation        (activation),
      .partial_sum_in    (partial_sum_in),
      .error_product_in  (error_product_in),
      .error_in          (error_in),
      .delay_clk         (delay_clk),
      .next_activation   (next_activation),
      .partial_sum_out   (partial_sum_out),
      .error_product_out (error_product_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of operands (called just after a falling edge), predict, then check.
   task automatic apply(input string tag, input int w, input int a, input int ps,
                        input int ep, input bit err, input bit dly);
      longint prod, comp, full, base;
      weight           = w[7:0];
      activation       = a[7:0];
      partial_sum_in   = ps[23:0];
      error_product_in = ep[15:0];
      error_in         = err;
      delay_clk        = dly;
      prod = longint'(w) * longint'(a);
      comp = err ? longint'(ep) : 0;
      full = (longint'(ps) + prod + comp) % (64'd1 << 24);
      base = (longint'(ps) + comp) % (64'd1 << 24);
      if (dly && full != m_ps) begin
         m_ps = base;
         m_ep = prod;
      end else begin
         m_ps = full;
         m_ep = 0;
      end
      m_act = a;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".ps"},  32'(partial_sum_out),   32'(m_ps));
      chk({tag, ".ep"},  32'(error_product_out), 32'(m_ep));
      chk({tag, ".act"}, 32'(next_activation),   32'(m_act));
   endtask

   initial begin
      int w, a, ps, ep;
      bit err, dly;
      rst_n            = 1'b0;
      weight           = 8'hA5;
      activation       = 8'h3C;
      partial_sum_in   = 24'h123456;
      error_product_in = 16'hBEEF;
      error_in         = 1'b1;
      delay_clk        = 1'b1;
      m_ps = 0; m_ep = 0; m_act = 0;
      #3;
      chk("rst.ps",  32'(partial_sum_out),   32'd0);
      chk("rst.ep",  32'(error_product_out), 32'd0);
      chk("rst.act", 32'(next_activation),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      apply("t2",   'h10, 'h02, 'h004000, 'h0000, 1'b0, 1'b0);
      chk("t2.lit", 32'(partial_sum_out), 32'h004020);
      apply("t3",   'h20, 'h03, 'h000008, 'h0012, 1'b0, 1'b0);
      chk("t3.lit", 32'(partial_sum_out), 32'h000068);
      apply("t4",   'h10, 'h02, 'h002000, 'h0012, 1'b1, 1'b0);
      chk("t4.lit", 32'(partial_sum_out), 32'h002032);

      apply("t5a",  'h10, 'h02, 'h004000, 'h0000, 1'b0, 1'b0);
      apply("t5b",  'h10, 'h02, 'h008000, 'h0000, 1'b0, 1'b1);
      chk("t5b.lit_ps", 32'(partial_sum_out),   32'h008000);
      chk("t5b.lit_ep", 32'(error_product_out), 32'h0020);
      apply("t5c",  'h10, 'h02, 'h004000, 'h0000, 1'b0, 1'b0);
      apply("t5d",  'h10, 'h02, 'h004000, 'h0000, 1'b0, 1'b1);
      chk("t5d.lit_ps", 32'(partial_sum_out),   32'h004020);
      chk("t5d.lit_ep", 32'(error_product_out), 32'h0000);

      apply("t6",   'hFF, 'hFF, 'hFFFFF0, 'h0000, 1'b0, 1'b0);
      chk("t6.lit", 32'(partial_sum_out), 32'h00FDF1);

      // Error cycle still adds upstream compensation; zero product owes nothing.
      apply("cmpa", 'h10, 'h02, 'h004000, 'h0000, 1'b0, 1'b0);
      apply("cmpb", 'h10, 'h02, 'h008000, 'h0005, 1'b1, 1'b1);
      chk("cmpb.lit", 32'(partial_sum_out), 32'h008005);
      apply("zero", 'h00, 'h44, 'h000100, 'h0000, 1'b0, 1'b1);
      chk("zero.lit", 32'(error_product_out), 32'h0000);

      // Asynchronous reset between edges drops a pending deferred product.
      apply("prer", 'h10, 'h02, 'h00F000, 'h0000, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.ps", 32'(partial_sum_out),   32'd0);
      chk("arst.ep", 32'(error_product_out), 32'd0);
      chk("arst.act", 32'(next_activation),  32'd0);
      m_ps = 0; m_ep = 0; m_act = 0;
      @(negedge clk);
      rst_n = 1'b1;

      w = 0; a = 0; ps = 0; ep = 0; err = 0;
      for (int i = 0; i < 400; i++) begin
         int mode;
         mode = $urandom_range(0, 9);
         if (mode < 3) begin
            dly = 1'b1;
         end else begin
            w   = $urandom_range(0, 255);
            a   = $urandom_range(0, 255);
            ps  = int'($urandom() & 32'hFFFFFF);
            if (mode == 9) ps = 'hFFFF00 + $urandom_range(0, 255);
            ep  = int'($urandom() & 32'hFFFF);
            err = $urandom_range(0, 1);
            dly = (mode < 5);
         end
         apply($sformatf("rnd%0d", i), w, a, ps, ep, err, dly);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
